// File: rtl/dir_input_conditioner.sv
// dir_input_conditioner: conditions the four active-low direction buttons for the motion logic.
// Each button is synchronised and debounced. Conflicting presses are flagged. The block emits
// rate-limited one-clock step strobes, one bit per direction.
// Optional feature: define DIR_COND_ACCEL_EN to double the repeat rate after a long hold.
module dir_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned TICK_DIV        = 1250000
`ifdef DIR_COND_ACCEL_EN
   ,
   parameter int unsigned ACCEL_HOLD      = 8
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] gpio,
   output logic [3:0] dir,
   output logic [3:0] step,
   output logic       conflict,
   output logic       err_latch,
   output logic [7:0] press_cnt
);

   localparam int unsigned DbW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned TkW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TkW-1:0] TkLast = TkW'(TICK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StHeld, StBlock} state_e;

   logic [3:0]     sync1_q, sync2_q;
   logic [3:0]     pressed;
   logic [DbW-1:0] db_cnt_q [4];
   logic [3:0]     dir_q;
   logic [TkW-1:0] tick_q;
   state_e         state_q;
   logic [3:0]     held_dir_q;
   logic [3:0]     step_q;
   logic           conflict_q;
   logic           err_q;
   logic [7:0]     cnt_q;
   logic           one_hot, multi, new_press, tick, fire;

   // Two-flop synchroniser; released buttons read as 1, so reset to all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 4'b1111;
         sync2_q <= 4'b1111;
      end else begin
         sync1_q <= gpio;
         sync2_q <= sync1_q;
      end
   end

   assign pressed = ~sync2_q;

   // Per-bit debounce: a level change is accepted only after it has stayed stable long enough.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir_q <= 4'b0000;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (pressed[i] == dir_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DbLast) begin
               dir_q[i]    <= ~dir_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign one_hot   = (dir_q != 4'b0000) && ((dir_q & (dir_q - 4'd1)) == 4'b0000);
   assign multi     = (dir_q != 4'b0000) && !one_hot;
   // A press is a one-hot level that the FSM is not already holding (covers direct swaps).
   assign new_press = one_hot && ((state_q != StHeld) || (dir_q != held_dir_q));
   assign tick      = (tick_q == TkLast);

   // Repeat tick counter; restarts on each press so the first repeat is a full period later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_q <= '0;
      end else if (new_press || tick) begin
         tick_q <= '0;
      end else begin
         tick_q <= tick_q + 1'b1;
      end
   end

`ifdef DIR_COND_ACCEL_EN
   localparam int unsigned HoW = (ACCEL_HOLD > 1) ? $clog2(ACCEL_HOLD + 1) : 1;
   localparam logic [HoW-1:0] HoMax  = HoW'(ACCEL_HOLD);
   localparam logic [TkW-1:0] TkHalf = TkW'(TICK_DIV / 2 - 1);

   logic [HoW-1:0] hold_q;

   // Counts repeat ticks of an unbroken hold in one direction, saturating at the accel threshold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q <= '0;
      end else if (!one_hot || new_press) begin
         hold_q <= '0;
      end else if (tick && (hold_q != HoMax)) begin
         hold_q <= hold_q + 1'b1;
      end
   end

   // Once accelerated, an extra strobe lands halfway through each tick period.
   assign fire = tick || ((hold_q == HoMax) && (tick_q == TkHalf));
`else
   assign fire = tick;
`endif

   // Step FSM with registered outputs: strobe on press and on repeat, block on conflicts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         held_dir_q <= 4'b0000;
         step_q     <= 4'b0000;
         conflict_q <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= 8'd0;
      end else begin
         step_q     <= 4'b0000;
         conflict_q <= multi;
         if (dir_q == 4'b0000) begin
            state_q    <= StIdle;
            held_dir_q <= 4'b0000;
            err_q      <= 1'b0;
         end else if (multi) begin
            state_q    <= StBlock;
            held_dir_q <= 4'b0000;
            err_q      <= 1'b1;
         end else if (new_press) begin
            state_q    <= StHeld;
            held_dir_q <= dir_q;
            step_q     <= dir_q;
            cnt_q      <= cnt_q + 8'd1;
         end else if (fire) begin
            step_q     <= dir_q;
         end
      end
   end

   assign dir       = dir_q;
   assign step      = step_q;
   assign conflict  = conflict_q;
   assign err_latch = err_q;
   assign press_cnt = cnt_q;

endmodule

// File: tb/tb_dir_input_conditioner.sv
// Bench for dir_input_conditioner with small timing parameters and a behavioural reference model.
module tb_dir_input_conditioner;

   localparam int unsigned DC = 4;
   localparam int unsigned TD = 10;
   localparam int unsigned AH = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] gpio = 4'hF;
   logic [3:0] dir, step;
   logic       conflict, err_latch;
   logic [7:0] press_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

`ifdef DIR_COND_ACCEL_EN
   dir_input_conditioner #(.DEBOUNCE_CYCLES(DC), .TICK_DIV(TD), .ACCEL_HOLD(AH)) dut (
`else
   dir_input_conditioner #(.DEBOUNCE_CYCLES(DC), .TICK_DIV(TD)) dut (
`endif
      .clk       (clk),
      .reset_n   (reset_n),
      .gpio      (gpio),
      .dir       (dir),
      .step      (step),
      .conflict  (conflict),
      .err_latch (err_latch),
      .press_cnt (press_cnt)
   );

   // Reference model: steps are derived from edges elapsed since the accepted press.
   logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_dir = 4'h0, m_step = 4'h0, m_held = 4'h0;
   logic       m_conf = 1'b0, m_err = 1'b0;
   logic [7:0] m_cnt = 8'd0;
   int         m_run [4];
   int         m_since = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_s1 = 4'hF; m_s2 = 4'hF; m_dir = 4'h0; m_step = 4'h0; m_held = 4'h0;
         m_conf = 1'b0; m_err = 1'b0; m_cnt = 8'd0; m_since = 0;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
      end else begin
         m_step = 4'h0;
         m_conf = ($countones(m_dir) > 1);
         if (m_dir == 4'h0) begin
            m_held = 4'h0; m_err = 1'b0;
         end else if ($countones(m_dir) > 1) begin
            m_held = 4'h0; m_err = 1'b1;
         end else if (m_dir != m_held) begin
            m_held = m_dir; m_since = 0; m_step = m_dir; m_cnt = m_cnt + 8'd1;
         end else begin
            m_since++;
            if (m_since % TD == 0) m_step = m_dir;
`ifdef DIR_COND_ACCEL_EN
            if (m_since > AH * TD && m_since % TD == TD / 2) m_step = m_dir;
`endif
         end
         for (int i = 0; i < 4; i++) begin
            if (!m_s2[i] != m_dir[i]) begin
               m_run[i]++;
               if (m_run[i] == DC) begin
                  m_dir[i] = ~m_dir[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = gpio;
      end
   end

   logic [17:0] got, want;
   assign got  = {dir, step, conflict, err_latch, press_cnt};
   assign want = {m_dir, m_step, m_conf, m_err, m_cnt};

   task automatic test_reset();
      reset_n = 1'b0;
      gpio = 4'b1110;
      repeat (3) @(negedge clk);
      n_checks++;
      if (got !== 18'd0) begin
         n_fail++; $display("FAIL reset_outputs got=%h want=0", got);
      end
      reset_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL reset_model c=%0d got=%h want=%h", c, got, want);
         end
         if (c == 5) begin
            n_checks++;
            if (dir !== 4'b0000) begin
               n_fail++; $display("FAIL reset_dir_early got=%b want=0000", dir);
            end
         end
         if (c == 6) begin
            n_checks++;
            if (dir !== 4'b0001) begin
               n_fail++; $display("FAIL reset_dir_clk6 got=%b want=0001", dir);
            end
         end
         if (c == 7) begin
            n_checks++;
            if (step !== 4'b0001) begin
               n_fail++; $display("FAIL reset_first_step got=%b want=0001", step);
            end
         end
      end
      gpio = 4'hF;
      repeat (10) begin
         @(negedge clk);
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL reset_release_model got=%h want=%h", got, want);
         end
      end
   endtask

   task automatic test_glitch();
      logic [7:0] start_cnt;
      int pulses, dir_seen;
      start_cnt = press_cnt;
      pulses = 0;
      dir_seen = 0;
      gpio = 4'b1101;
      for (int c = 0; c < 15; c++) begin
         if (c == 3) gpio = 4'hF;
         @(negedge clk);
         if (step !== 4'b0000) pulses++;
         if (dir !== 4'b0000) dir_seen++;
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL glitch_model c=%0d got=%h want=%h", c, got, want);
         end
      end
      n_checks++;
      if (pulses != 0 || dir_seen != 0 || press_cnt !== start_cnt) begin
         n_fail++;
         $display("FAIL glitch_effect pulses=%0d dir_cycles=%0d cnt=%0d want 0/0/%0d",
                  pulses, dir_seen, press_cnt, start_cnt);
      end
   endtask

   task automatic test_hold_right();
      logic [7:0] start_cnt;
      int pulses, bad, first, second, exp_pulses;
      start_cnt = press_cnt;
      pulses = 0; bad = 0; first = -1; second = -1;
`ifdef DIR_COND_ACCEL_EN
      exp_pulses = 5;
`else
      exp_pulses = 4;
`endif
      gpio = 4'b1101;
      for (int c = 1; c <= 50; c++) begin
         if (c == 36) gpio = 4'hF;
         @(negedge clk);
         if (step !== 4'b0000) begin
            pulses++;
            if (step !== 4'b0010) bad++;
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL hold_model c=%0d got=%h want=%h", c, got, want);
         end
      end
      n_checks++;
      if (pulses != exp_pulses || bad != 0) begin
         n_fail++; $display("FAIL hold_pulses got=%0d bad=%0d want=%0d", pulses, bad, exp_pulses);
      end
      n_checks++;
      if (first != 7 || second - first != 10) begin
         n_fail++; $display("FAIL hold_timing first=%0d gap=%0d want 7/10", first, second - first);
      end
      n_checks++;
      if (press_cnt !== start_cnt + 8'd1) begin
         n_fail++; $display("FAIL hold_cnt got=%0d want=%0d", press_cnt, start_cnt + 8'd1);
      end
   endtask

   task automatic test_conflict();
      logic [7:0] start_cnt;
      int pulses, first;
      gpio = 4'b1110;
      repeat (10) begin
         @(negedge clk);
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL conflict_down_model got=%h want=%h", got, want);
         end
      end
      gpio = 4'b1010;
      repeat (10) begin
         @(negedge clk);
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL conflict_both_model got=%h want=%h", got, want);
         end
      end
      n_checks++;
      if (conflict !== 1'b1 || err_latch !== 1'b1 || step !== 4'b0000) begin
         n_fail++;
         $display("FAIL conflict_flags conf=%b err=%b step=%b want 1/1/0000", conflict, err_latch,
                  step);
      end
      start_cnt = press_cnt;
      pulses = 0; first = -1;
      gpio = 4'b1110;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (step === 4'b0001) begin
            pulses++;
            if (first < 0) first = c;
         end
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL conflict_return_model c=%0d got=%h want=%h", c, got, want);
         end
      end
      n_checks++;
      if (pulses != 1 || first != 7 || press_cnt !== start_cnt + 8'd1 || err_latch !== 1'b1) begin
         n_fail++;
         $display("FAIL conflict_return pulses=%0d at=%0d cnt=%0d err=%b want 1/7/%0d/1", pulses,
                  first, press_cnt, err_latch, start_cnt + 8'd1);
      end
      gpio = 4'hF;
      repeat (10) begin
         @(negedge clk);
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL conflict_release_model got=%h want=%h", got, want);
         end
      end
      n_checks++;
      if (err_latch !== 1'b0 || conflict !== 1'b0) begin
         n_fail++; $display("FAIL conflict_clear err=%b conf=%b want 0/0", err_latch, conflict);
      end
   endtask

   task automatic test_reset_midhold();
      gpio = 4'b1110;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (got !== 18'd0) begin
         n_fail++; $display("FAIL midhold_reset got=%h want=0", got);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL midhold_model c=%0d got=%h want=%h", c, got, want);
         end
         if (c == 5) begin
            n_checks++;
            if (dir !== 4'b0000) begin
               n_fail++; $display("FAIL midhold_dir_early got=%b want=0000", dir);
            end
         end
      end
      gpio = 4'hF;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_wrap();
      reset_n = 1'b0;
      gpio = 4'hF;
      @(negedge clk);
      reset_n = 1'b1;
      for (int p = 1; p <= 256; p++) begin
         gpio = 4'b0111;
         repeat (8) begin
            @(negedge clk);
            n_checks++;
            if (got !== want) begin
               n_fail++; $display("FAIL wrap_model p=%0d got=%h want=%h", p, got, want);
            end
         end
         gpio = 4'hF;
         repeat (8) @(negedge clk);
         if (p == 255) begin
            n_checks++;
            if (press_cnt !== 8'd255) begin
               n_fail++; $display("FAIL wrap_255 got=%0d want=255", press_cnt);
            end
         end
      end
      n_checks++;
      if (press_cnt !== 8'd0) begin
         n_fail++; $display("FAIL wrap_zero got=%0d want=0", press_cnt);
      end
   endtask

   task automatic test_accel();
      int pulses, prev, gap, exp_pulses, exp_gap;
      pulses = 0; prev = -1; gap = 0;
`ifdef DIR_COND_ACCEL_EN
      exp_pulses = 10; exp_gap = 5;
`else
      exp_pulses = 6; exp_gap = 10;
`endif
      gpio = 4'b0111;
      for (int c = 1; c <= 75; c++) begin
         if (c == 61) gpio = 4'hF;
         @(negedge clk);
         if (step !== 4'b0000) begin
            pulses++;
            if (prev >= 0) gap = c - prev;
            prev = c;
         end
         n_checks++;
         if (got !== want) begin
            n_fail++; $display("FAIL accel_model c=%0d got=%h want=%h", c, got, want);
         end
      end
      n_checks++;
      if (pulses != exp_pulses || gap != exp_gap) begin
         n_fail++;
         $display("FAIL accel_spacing pulses=%0d gap=%0d want %0d/%0d", pulses, gap, exp_pulses,
                  exp_gap);
      end
   endtask

   task automatic test_random();
      int hold;
      for (int s = 0; s < 200; s++) begin
         case ($urandom_range(0, 3))
            0:       gpio = 4'hF;
            1, 2:    gpio = ~(4'b0001 << $urandom_range(0, 3));
            default: gpio = 4'($urandom);
         endcase
         hold = $urandom_range(1, 14);
         repeat (hold) begin
            @(negedge clk);
            n_checks++;
            if (got !== want) begin
               n_fail++; $display("FAIL random_model seg=%0d got=%h want=%h", s, got, want);
            end
         end
      end
      gpio = 4'hF;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_hold_right();
      test_conflict();
      test_reset_midhold();
      test_accel();
      test_random();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
